sram_bus_arbiter: RTL and testbench
===================================

# sram_bus_arbiter

Shares one asynchronous 32-bit external SRAM between the instruction-fetch port (PC side) and the data-memory port (MEM stage). It runs a fixed-length multi-cycle SRAM access per request and raises per-port stall requests toward the pipeline controller until that port's access completes. When both ports request together, the data port has priority. A flush discards an in-flight fetch.

## Interface
- WAIT_CYCLES, 1: SRAM cycles during which `sram_we_n` is held low; an access lasts WAIT_CYCLES+1 cycles (legal values 1..7)
- SRAM_AW, 20: SRAM word-address width
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset
- flush  in  1  pipeline flush from the controller
- if_ce  in  1  fetch request (read only)
- if_addr  in  32  fetch byte address
- if_data  out  32  fetched word, valid with if_ready
- if_ready  out  1  one-cycle completion pulse
- mem_ce  in  1  data request
- mem_we  in  1  1 = write, 0 = read
- mem_sel  in  4  byte enables, active-high
- mem_addr  in  32  data byte address
- mem_wdata  in  32  write data
- mem_rdata  out  32  read word, valid with mem_ready
- mem_ready  out  1  one-cycle completion pulse
- stallreq_if  out  1  fetch not yet served
- stallreq_mem  out  1  data access not yet served
- sram_addr  out  SRAM_AW  word address
- sram_data_o  out  32  write data to the pad
- sram_data_i  in  32  read data from the pad
- sram_data_oe  out  1  pad drive enable
- sram_ce_n, sram_oe_n, sram_we_n  out  1 each  SRAM strobes, active-low
- sram_be_n  out  4  byte enables, active-low

## Operation
- FSM states: IDLE, ACCESS, DONE. There is also a grant register: NONE, IF, or MEM.
- IDLE:
  - If mem_ce, grant MEM; otherwise if if_ce, grant IF.
  - On a grant, go to ACCESS and load the down-counter with WAIT_CYCLES.
  - If neither port requests, stay in IDLE.
- At grant, latch the request:
  - sram_addr = addr[SRAM_AW+1:2].
  - Data writes: sram_be_n = ~mem_sel. Data reads and fetches: sram_be_n = 4'b0000.
- ACCESS (WAIT_CYCLES+1 cycles): sram_ce_n = 0, and the address and byte enables are held constant.
  - Read: sram_oe_n = 0 and sram_data_oe = 0 throughout. On the last ACCESS cycle, register sram_data_i into if_data or mem_rdata, according to the grant.
  - Write: sram_data_oe = 1 and sram_oe_n = 1 throughout. sram_we_n = 0 while the counter is nonzero and 1 on the last cycle (data hold).
  - Exit to DONE when the counter is 0; otherwise decrement.
- DONE (1 cycle):
  - Strobes are idle and sram_data_oe = 0.
  - Pulse the granted port's ready, unless that access is discarded.
  - Return to IDLE. Every access is followed by exactly one DONE/turnaround cycle.
- Stall requests (combinational):
  - stallreq_mem = mem_ce & ~mem_ready.
  - stallreq_if = if_ce & ~if_ready.
- Flush:
  - While grant = IF in ACCESS or DONE, flush sets a discard flag. The SRAM cycle still completes, but if_ready is suppressed and if_data is not updated.
  - Data accesses are never aborted.
  - Flush in IDLE has no effect.
- Requests must stay stable until ready. If ce drops mid-access, the access still completes. Its ready pulse is issued, and the requester ignores it.
- All SRAM outputs, ready pulses and data outputs are registered.

## Timing
- Reset values: state IDLE, grant NONE, counter 0, sram_ce_n/oe_n/we_n = 1, sram_be_n = 4'hF, sram_addr = 0, sram_data_o = 0, sram_data_oe = 0, if_ready = mem_ready = 0, if_data = mem_rdata = 0, discard flag 0.
- Reset asserted mid-access returns the block to these values immediately; no write completes.
- Latency for a request seen in IDLE at cycle t:
  - ACCESS occupies t+1 .. t+1+WAIT_CYCLES.
  - The ready pulse occurs at t+2+WAIT_CYCLES.
  - The next grant decision is made at t+3+WAIT_CYCLES.
  - With the default parameters, ready arrives 3 cycles after the request and back-to-back accesses issue every 4 cycles.
- Simultaneous if_ce and mem_ce in IDLE: MEM is served first. The IF grant follows at the next IDLE, with no starvation beyond one data access.
- A request that arrives during ACCESS or DONE waits for the next IDLE.

## Test plan
- Reset, then release with no requests: all SRAM strobes stay 1, sram_be_n = F, both stall requests 0.
- Fetch: if_ce = 1, if_addr = 0x80000010, SRAM returns 0x24010001.
  - sram_addr = 0x00004, sram_oe_n low for 2 cycles.
  - if_ready pulses at cycle 3 with if_data = 0x24010001.
  - stallreq_if is high for cycles 0–2.
- Byte write: mem_we = 1, mem_sel = 4'b0010, mem_addr = 0x80000104, mem_wdata = 0xAABBCCDD.
  - sram_be_n = 4'b1101, sram_addr = 0x00041.
  - sram_we_n low for 1 cycle, then high for 1 cycle, with sram_data_oe high during both.
  - mem_ready pulses at cycle 3.
- Simultaneous fetch and data read:
  - mem_ready at cycle 3.
  - if_ready at cycle 7.
  - stallreq_if stays high through cycle 6.
- Flush at cycle 2 of a fetch: no if_ready pulse, if_data unchanged, FSM back in IDLE at cycle 4.
- Reset asserted during a write's ACCESS: sram_we_n and sram_ce_n go to 1 at once, the state returns to IDLE, and no mem_ready pulse is issued.

Source files
------------

// File: rtl/sram_bus_arbiter_if.sv
// ---------------------------------------------------------------------------
// sram_bus_arbiter_if
//
// Groups every signal of the SRAM bus arbiter apart from clock and reset: the
// instruction-fetch port, the data-memory port, the flush and stall-request
// lines towards the pipeline controller, and the external SRAM pad signals.
//
// Modports
//   master : the arbiter's view. It serves the two request ports, produces the
//            stall requests and drives the SRAM strobes.
//   slave  : the surroundings' view (pipeline + SRAM pad). It issues requests
//            and returns read data from the pad.
//
// Handshake: a port raises *_ce with its address (and write data/byte enables
// for the data port). It holds them stable until its *_ready pulses for one
// cycle, and *_rdata / if_data are valid in that same cycle. stallreq_* is
// high while that port's ce is high and its ready has not yet pulsed.
//
// Signals
//   flush                                     pipeline flush (discards a fetch)
//   if_ce, if_addr / if_data, if_ready        fetch port (read only)
//   mem_ce, mem_we, mem_sel, mem_addr,
//   mem_wdata / mem_rdata, mem_ready          data port
//   stallreq_if, stallreq_mem                 per-port stall requests
//   sram_addr, sram_data_o, sram_data_i,
//   sram_data_oe, sram_ce_n, sram_oe_n,
//   sram_we_n, sram_be_n                      asynchronous SRAM pad
// ---------------------------------------------------------------------------
interface sram_bus_arbiter_if #(
    parameter int SRAM_AW = 20
);
    logic               flush;

    logic               if_ce;
    logic [31:0]        if_addr;
    logic [31:0]        if_data;
    logic               if_ready;

    logic               mem_ce;
    logic               mem_we;
    logic [3:0]         mem_sel;
    logic [31:0]        mem_addr;
    logic [31:0]        mem_wdata;
    logic [31:0]        mem_rdata;
    logic               mem_ready;

    logic               stallreq_if;
    logic               stallreq_mem;

    logic [SRAM_AW-1:0] sram_addr;
    logic [31:0]        sram_data_o;
    logic [31:0]        sram_data_i;
    logic               sram_data_oe;
    logic               sram_ce_n;
    logic               sram_oe_n;
    logic               sram_we_n;
    logic [3:0]         sram_be_n;

    modport master (
        input  flush,
        input  if_ce, if_addr,
        output if_data, if_ready,
        input  mem_ce, mem_we, mem_sel, mem_addr, mem_wdata,
        output mem_rdata, mem_ready,
        output stallreq_if, stallreq_mem,
        output sram_addr, sram_data_o, sram_data_oe,
        output sram_ce_n, sram_oe_n, sram_we_n, sram_be_n,
        input  sram_data_i
    );

    modport slave (
        output flush,
        output if_ce, if_addr,
        input  if_data, if_ready,
        output mem_ce, mem_we, mem_sel, mem_addr, mem_wdata,
        input  mem_rdata, mem_ready,
        input  stallreq_if, stallreq_mem,
        input  sram_addr, sram_data_o, sram_data_oe,
        input  sram_ce_n, sram_oe_n, sram_we_n, sram_be_n,
        output sram_data_i
    );
endinterface

// File: rtl/sram_bus_arbiter.sv
// ---------------------------------------------------------------------------
// sram_bus_arbiter
//
// Shares one asynchronous 32-bit SRAM between the instruction-fetch port and
// the data-memory port. Each granted request runs a fixed access of
// WAIT_CYCLES+1 cycles (ACCESS), followed by one turnaround cycle (DONE) in
// which the granted port's ready pulses. When both ports request in the same
// IDLE cycle, the data port wins. A flush while a fetch is in ACCESS lets the
// SRAM cycle finish, but suppresses if_ready and leaves if_data untouched.
//
// Parameters
//   WAIT_CYCLES  cycles with sram_we_n low on a write (1..7)
//   SRAM_AW      SRAM word-address width
//
// Ports
//   clk        system clock, rising edge
//   rst        asynchronous reset, active low
//   bus        sram_bus_arbiter_if.master (request ports, stalls, SRAM pad)
//   dbg_state  current FSM state (0 IDLE, 1 ACCESS, 2 DONE)
//   dbg_grant  current grant (0 NONE, 1 IF, 2 MEM)
//
// Every SRAM output, ready pulse and data output is a register. Only the
// stall requests are combinational.
// ---------------------------------------------------------------------------
module sram_bus_arbiter #(
    parameter int WAIT_CYCLES = 1,
    parameter int SRAM_AW     = 20
) (
    input  logic                clk,
    input  logic                rst,
    sram_bus_arbiter_if.master  bus,
    output logic [1:0]          dbg_state,
    output logic [1:0]          dbg_grant
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        G_NONE = 2'd0,
        G_IF   = 2'd1,
        G_MEM  = 2'd2
    } grant_t;

    // Three bits hold the largest legal WAIT_CYCLES (7).
    localparam int            CW       = 3;
    localparam logic [CW-1:0] CNT_LOAD = CW'(WAIT_CYCLES);

    // ------------------------------------------------------------------
    // FSM and bookkeeping registers
    // ------------------------------------------------------------------
    state_t        state_q, state_d;
    grant_t        grant_q, grant_d;
    logic [CW-1:0] cnt_q,   cnt_d;
    logic          discard_q, discard_d;
    logic          is_write_q;

    // ------------------------------------------------------------------
    // Registered outputs
    // ------------------------------------------------------------------
    logic [SRAM_AW-1:0] addr_q;
    logic [31:0]        data_o_q;
    logic               data_oe_q;
    logic               ce_n_q;
    logic               oe_n_q;
    logic               we_n_q;
    logic [3:0]         be_n_q;
    logic               if_ready_q;
    logic               mem_ready_q;
    logic [31:0]        if_data_q;
    logic [31:0]        mem_rdata_q;

    // ------------------------------------------------------------------
    // Request selection (only meaningful while IDLE)
    // ------------------------------------------------------------------
    logic               sel_mem;
    logic               grant_start;
    logic               new_write;
    logic [SRAM_AW-1:0] req_word;
    logic               last_access;

    // Data port has fixed priority over fetch.
    assign sel_mem     = bus.mem_ce;
    assign grant_start = (state_q == S_IDLE) && (bus.mem_ce || bus.if_ce);
    assign new_write   = sel_mem && bus.mem_we;
    assign req_word    = sel_mem ? bus.mem_addr[SRAM_AW+1:2]
                                 : bus.if_addr[SRAM_AW+1:2];
    assign last_access = (state_q == S_ACCESS) && (cnt_q == '0);

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            grant_q   <= G_NONE;
            cnt_q     <= '0;
            discard_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            cnt_q     <= cnt_d;
            discard_q <= discard_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        cnt_d     = cnt_q;
        discard_d = discard_q;

        case (state_q)
            S_IDLE: begin
                // A fresh access never inherits a stale discard.
                discard_d = 1'b0;
                grant_d   = G_NONE;
                if (grant_start) begin
                    state_d = S_ACCESS;
                    grant_d = sel_mem ? G_MEM : G_IF;
                    cnt_d   = CNT_LOAD;
                end
            end

            S_ACCESS: begin
                if ((grant_q == G_IF) && bus.flush) begin
                    discard_d = 1'b1;
                end
                if (cnt_q == '0) begin
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end

            S_DONE: begin
                // A flush here is remembered but can no longer retract the
                // ready pulse, which was already registered on entry to DONE.
                if ((grant_q == G_IF) && bus.flush) begin
                    discard_d = 1'b1;
                end
                state_d = S_IDLE;
            end

            default: begin
                state_d   = S_IDLE;
                grant_d   = G_NONE;
                cnt_d     = '0;
                discard_d = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // SRAM strobes, ready pulses and read data
    //
    // Each register is loaded with the value it must present in the next
    // cycle, so the strobes line up exactly with the ACCESS/DONE states.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr_q      <= '0;
            data_o_q    <= '0;
            data_oe_q   <= 1'b0;
            ce_n_q      <= 1'b1;
            oe_n_q      <= 1'b1;
            we_n_q      <= 1'b1;
            be_n_q      <= 4'hF;
            if_ready_q  <= 1'b0;
            mem_ready_q <= 1'b0;
            if_data_q   <= '0;
            mem_rdata_q <= '0;
            is_write_q  <= 1'b0;
        end else begin
            if_ready_q  <= 1'b0;
            mem_ready_q <= 1'b0;

            if (grant_start) begin
                // Latch the winning request; it stays constant for the access.
                addr_q     <= req_word;
                is_write_q <= new_write;
                be_n_q     <= new_write ? ~bus.mem_sel : 4'b0000;
                if (new_write) begin
                    data_o_q <= bus.mem_wdata;
                end
                ce_n_q    <= 1'b0;
                oe_n_q    <= new_write;
                // The counter loads WAIT_CYCLES >= 1, so a write's first
                // ACCESS cycle always has the write strobe low.
                we_n_q    <= ~new_write;
                data_oe_q <= new_write;
            end else if (last_access) begin
                // Going to DONE: release the bus and capture read data.
                ce_n_q    <= 1'b1;
                oe_n_q    <= 1'b1;
                we_n_q    <= 1'b1;
                data_oe_q <= 1'b0;
                be_n_q    <= 4'hF;
                if (grant_q == G_IF) begin
                    // A flush in this very cycle still counts as a discard.
                    if (!discard_q && !bus.flush) begin
                        if_ready_q <= 1'b1;
                        if_data_q  <= bus.sram_data_i;
                    end
                end else if (grant_q == G_MEM) begin
                    mem_ready_q <= 1'b1;
                    if (!is_write_q) begin
                        mem_rdata_q <= bus.sram_data_i;
                    end
                end
            end else if (state_q == S_ACCESS) begin
                // The write strobe rises for the final ACCESS cycle so that
                // the data is held past the end of the write pulse.
                we_n_q <= ~(is_write_q && (cnt_d != '0));
            end
        end
    end

    // ------------------------------------------------------------------
    // Output wiring
    // ------------------------------------------------------------------
    assign bus.sram_addr    = addr_q;
    assign bus.sram_data_o  = data_o_q;
    assign bus.sram_data_oe = data_oe_q;
    assign bus.sram_ce_n    = ce_n_q;
    assign bus.sram_oe_n    = oe_n_q;
    assign bus.sram_we_n    = we_n_q;
    assign bus.sram_be_n    = be_n_q;

    assign bus.if_ready     = if_ready_q;
    assign bus.if_data      = if_data_q;
    assign bus.mem_ready    = mem_ready_q;
    assign bus.mem_rdata    = mem_rdata_q;

    // A port stalls from the cycle it asks until the cycle it is answered.
    assign bus.stallreq_if  = bus.if_ce  & ~if_ready_q;
    assign bus.stallreq_mem = bus.mem_ce & ~mem_ready_q;

    assign dbg_state = state_q;
    assign dbg_grant = grant_q;

endmodule

// File: tb/tb_sram_bus_arbiter.sv
// ---------------------------------------------------------------------------
// tb_sram_bus_arbiter
//
// Table of isolated transactions, hand sequences for arbitration, flush and
// reset-during-write, then randomized traffic checked against a
// transaction-level model of the arbiter.
// ---------------------------------------------------------------------------
module tb_sram_bus_arbiter;

    localparam int W  = 1;
    localparam int AW = 20;
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam int N_RND = 3000;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [1:0] dbg_state;
    logic [1:0] dbg_grant;

    sram_bus_arbiter_if #(.SRAM_AW(AW)) bus();

    sram_bus_arbiter #(.WAIT_CYCLES(W), .SRAM_AW(AW)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .dbg_state (dbg_state),
        .dbg_grant (dbg_grant)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard counters ----------------
    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- SRAM pad model ----------------
    bit [31:0] sram_mem [0:(1<<AW)-1];
    bit        we_seen;

    // Data appears half a cycle after the strobes, like an async access.
    always @(negedge clk) begin
        if (!bus.sram_ce_n && !bus.sram_oe_n) bus.sram_data_i <= sram_mem[bus.sram_addr];
        else                                  bus.sram_data_i <= 32'h0;
    end

    function automatic logic [31:0] pad_merge(input logic [31:0] old, input logic [31:0] nw,
                                              input logic [3:0] be_n);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (!be_n[b]) r[8*b +: 8] = nw[8*b +: 8];
        return r;
    endfunction

    // A write lands only after a full low pulse of we_n followed by a hold
    // cycle with ce_n still low.
    always @(posedge clk) begin
        if (bus.sram_ce_n) begin
            we_seen <= 1'b0;
        end else if (!bus.sram_we_n) begin
            we_seen <= 1'b1;
        end else if (we_seen && bus.sram_data_oe) begin
            sram_mem[bus.sram_addr] <= pad_merge(sram_mem[bus.sram_addr], bus.sram_data_o,
                                                 bus.sram_be_n);
            we_seen <= 1'b0;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_reqs();
        bus.if_ce = 1'b0; bus.mem_ce = 1'b0; bus.mem_we = 1'b0; bus.flush = 1'b0;
    endtask

    task automatic idle(input int n);
        clear_reqs();
        repeat (n) step();
    endtask

    // Per-cycle capture of a directed sequence (cycle 0 = first request cycle).
    logic          r_ce_n [16], r_oe_n [16], r_we_n [16], r_doe [16];
    logic [3:0]    r_be_n [16];
    logic [AW-1:0] r_addr [16];
    logic [31:0]   r_do [16], r_ifd [16], r_memd [16];
    logic          r_ifr [16], r_memr [16], r_sif [16], r_smem [16];
    logic [1:0]    r_st [16];

    // Requesters drop ce the cycle after their ready; a flush at cycle
    // flush_at also redirects the fetcher, dropping if_ce the cycle after.
    task automatic capture(input int n, input int flush_at);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            r_ce_n[k] = bus.sram_ce_n;  r_oe_n[k] = bus.sram_oe_n;
            r_we_n[k] = bus.sram_we_n;  r_doe[k]  = bus.sram_data_oe;
            r_be_n[k] = bus.sram_be_n;  r_addr[k] = bus.sram_addr;
            r_do[k]   = bus.sram_data_o;
            r_ifr[k]  = bus.if_ready;   r_ifd[k]  = bus.if_data;
            r_memr[k] = bus.mem_ready;  r_memd[k] = bus.mem_rdata;
            r_sif[k]  = bus.stallreq_if; r_smem[k] = bus.stallreq_mem;
            r_st[k]   = dbg_state;
            step();
            if (r_ifr[k])  bus.if_ce  = 1'b0;
            if (r_memr[k]) bus.mem_ce = 1'b0;
            bus.flush = (flush_at > 0) && (k + 1 == flush_at);
            if ((flush_at > 0) && (k + 1 == flush_at + 1)) bus.if_ce = 1'b0;
        end
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        bit          is_if;
        bit          we;
        logic [3:0]  sel;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] pre;       // SRAM word before the access
        logic [19:0] exp_sa;    // expected sram_addr
        logic [3:0]  exp_be_n;
        logic [31:0] exp_word;  // read data, or SRAM word after a write
    } vec_t;

    vec_t vecs [7];

    task automatic run_vec(input int i);
        vec_t  v;
        logic  rdy [16];
        logic  stl [16];
        string p;
        v = vecs[i];
        p = $sformatf("v%0d", i);
        sram_mem[v.exp_sa] <= v.pre;
        idle(3);
        if (v.is_if) begin
            bus.if_ce = 1'b1; bus.if_addr = v.addr;
        end else begin
            bus.mem_ce = 1'b1; bus.mem_we = v.we; bus.mem_sel = v.sel;
            bus.mem_addr = v.addr; bus.mem_wdata = v.wdata;
        end
        capture(8, 0);
        rdy = v.is_if ? r_ifr : r_memr;
        stl = v.is_if ? r_sif : r_smem;

        chk({p, "_ce_n0"}, 32'(r_ce_n[0]), 32'd1);
        chk({p, "_ce_n1"}, 32'(r_ce_n[1]), 32'd0);
        chk({p, "_ce_n2"}, 32'(r_ce_n[2]), 32'd0);
        chk({p, "_ce_n3"}, 32'(r_ce_n[3]), 32'd1);
        chk({p, "_addr1"}, 32'(r_addr[1]), 32'(v.exp_sa));
        chk({p, "_addr2"}, 32'(r_addr[2]), 32'(v.exp_sa));
        chk({p, "_be_n1"}, 32'(r_be_n[1]), 32'(v.exp_be_n));
        chk({p, "_be_n2"}, 32'(r_be_n[2]), 32'(v.exp_be_n));
        if (v.we) begin
            chk({p, "_we_n1"}, 32'(r_we_n[1]), 32'd0);
            chk({p, "_we_n2"}, 32'(r_we_n[2]), 32'd1);
            chk({p, "_oe_n1"}, 32'(r_oe_n[1]), 32'd1);
            chk({p, "_doe1"},  32'(r_doe[1]),  32'd1);
            chk({p, "_doe2"},  32'(r_doe[2]),  32'd1);
            chk({p, "_dout1"}, r_do[1], v.wdata);
            chk({p, "_word"},  sram_mem[v.exp_sa], v.exp_word);
        end else begin
            chk({p, "_oe_n1"}, 32'(r_oe_n[1]), 32'd0);
            chk({p, "_oe_n2"}, 32'(r_oe_n[2]), 32'd0);
            chk({p, "_we_n1"}, 32'(r_we_n[1]), 32'd1);
            chk({p, "_doe1"},  32'(r_doe[1]),  32'd0);
            chk({p, "_rdata"}, v.is_if ? r_ifd[3] : r_memd[3], v.exp_word);
        end
        chk({p, "_doe3"},  32'(r_doe[3]),  32'd0);
        chk({p, "_oe_n3"}, 32'(r_oe_n[3]), 32'd1);
        chk({p, "_we_n3"}, 32'(r_we_n[3]), 32'd1);
        chk({p, "_rdy2"},  32'(rdy[2]), 32'd0);
        chk({p, "_rdy3"},  32'(rdy[3]), 32'd1);
        chk({p, "_rdy4"},  32'(rdy[4]), 32'd0);
        chk({p, "_other_rdy3"}, 32'(v.is_if ? r_memr[3] : r_ifr[3]), 32'd0);
        for (int k = 0; k < 3; k++) chk($sformatf("%s_stall%0d", p, k), 32'(stl[k]), 32'd1);
        chk({p, "_stall3"}, 32'(stl[3]), 32'd0);
    endtask

    // ---------------- reference model for random traffic ----------------
    logic [31:0] model_mem [logic [19:0]];

    function automatic logic [31:0] model_rd(input logic [19:0] key);
        return model_mem.exists(key) ? model_mem[key] : 32'h0;
    endfunction

    function automatic logic [31:0] rand_addr();
        logic [31:0] a;
        a = $urandom();
        a[21:8] = '0;          // keeps traffic on 64 words so reads hit writes
        return a;
    endfunction

    // ---------------- main sequence ----------------
    initial begin
        logic [31:0] exp_if_data, exp_mem_rdata;
        logic        mem_got, if_got;
        bit          sv, s_is_if, s_we, s_disc;
        int          s_start, s_done, free_at;
        logic [31:0] s_data;

        clear_reqs();
        bus.if_addr = '0; bus.mem_sel = '0; bus.mem_addr = '0; bus.mem_wdata = '0;

        vecs[0] = '{1'b1, 1'b0, 4'h0, 32'h80000010, 32'h0,        32'h24010001, 20'h00004, 4'h0, 32'h24010001};
        vecs[1] = '{1'b0, 1'b1, 4'h2, 32'h80000104, 32'hAABBCCDD, 32'h11223344, 20'h00041, 4'hD, 32'h1122CC44};
        vecs[2] = '{1'b0, 1'b0, 4'hF, 32'h80000020, 32'h0,        32'hDEADBEEF, 20'h00008, 4'h0, 32'hDEADBEEF};
        vecs[3] = '{1'b0, 1'b1, 4'hF, 32'h000000FC, 32'h01234567, 32'hFFFFFFFF, 20'h0003F, 4'h0, 32'h01234567};
        vecs[4] = '{1'b0, 1'b1, 4'h9, 32'h80000008, 32'hCAFEF00D, 32'h00000000, 20'h00002, 4'h6, 32'hCA00000D};
        vecs[5] = '{1'b1, 1'b0, 4'h0, 32'hFFFFFFFC, 32'h0,        32'h0BADF00D, 20'hFFFFF, 4'h0, 32'h0BADF00D};
        vecs[6] = '{1'b0, 1'b0, 4'h5, 32'h003FFFF8, 32'h0,        32'h76543210, 20'hFFFFE, 4'h0, 32'h76543210};

        // ---- reset and idle ----
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ce_n", 32'(bus.sram_ce_n), 32'd1);
        chk("rst_be_n", 32'(bus.sram_be_n), 32'hF);
        rst = 1'b1;
        idle(3);
        @(negedge clk);
        chk("idle_ce_n",  32'(bus.sram_ce_n), 32'd1);
        chk("idle_oe_n",  32'(bus.sram_oe_n), 32'd1);
        chk("idle_we_n",  32'(bus.sram_we_n), 32'd1);
        chk("idle_be_n",  32'(bus.sram_be_n), 32'hF);
        chk("idle_doe",   32'(bus.sram_data_oe), 32'd0);
        chk("idle_addr",  32'(bus.sram_addr), 32'd0);
        chk("idle_sif",   32'(bus.stallreq_if), 32'd0);
        chk("idle_smem",  32'(bus.stallreq_mem), 32'd0);
        chk("idle_state", 32'(dbg_state), 32'(ST_IDLE));
        chk("idle_ifd",   bus.if_data, 32'h0);

        // ---- table of single transactions ----
        for (int i = 0; i < 7; i++) run_vec(i);

        // ---- simultaneous fetch and data read ----
        sram_mem[20'h10] <= 32'h0F0F0F0F;
        sram_mem[20'h11] <= 32'hF0F0F0F0;
        idle(3);
        bus.if_ce = 1'b1;  bus.if_addr = 32'h80000040;
        bus.mem_ce = 1'b1; bus.mem_we = 1'b0; bus.mem_sel = 4'hF; bus.mem_addr = 32'h80000044;
        capture(10, 0);
        chk("sim_mem_rdy3", 32'(r_memr[3]), 32'd1);
        chk("sim_mem_data", r_memd[3], 32'hF0F0F0F0);
        chk("sim_if_rdy3",  32'(r_ifr[3]), 32'd0);
        chk("sim_if_rdy7",  32'(r_ifr[7]), 32'd1);
        chk("sim_if_data",  r_ifd[7], 32'h0F0F0F0F);
        chk("sim_addr1",    32'(r_addr[1]), 32'h11);
        chk("sim_addr5",    32'(r_addr[5]), 32'h10);
        for (int k = 0; k < 7; k++) chk($sformatf("sim_sif%0d", k), 32'(r_sif[k]), 32'd1);
        chk("sim_sif7",     32'(r_sif[7]), 32'd0);
        chk("sim_smem3",    32'(r_smem[3]), 32'd0);

        // ---- flush during a fetch ----
        sram_mem[20'h14] <= 32'h55555555;
        idle(3);
        bus.if_ce = 1'b1; bus.if_addr = 32'h80000050;
        capture(8, 2);
        for (int k = 0; k < 8; k++) chk($sformatf("fl_if_rdy%0d", k), 32'(r_ifr[k]), 32'd0);
        chk("fl_if_data", r_ifd[7], 32'h0F0F0F0F);
        chk("fl_ce_n2",   32'(r_ce_n[2]), 32'd0);
        chk("fl_ce_n3",   32'(r_ce_n[3]), 32'd1);
        chk("fl_state4",  32'(r_st[4]), 32'(ST_IDLE));

        // ---- reset during a write's ACCESS ----
        sram_mem[20'h20] <= 32'h12345678;
        idle(3);
        bus.mem_ce = 1'b1; bus.mem_we = 1'b1; bus.mem_sel = 4'hF;
        bus.mem_addr = 32'h80000080; bus.mem_wdata = 32'h9ABCDEF0;
        @(posedge clk);
        #3;
        chk("rw_we_n_low", 32'(bus.sram_we_n), 32'd0);
        rst = 1'b0;
        #1;
        chk("rw_we_n",  32'(bus.sram_we_n), 32'd1);
        chk("rw_ce_n",  32'(bus.sram_ce_n), 32'd1);
        chk("rw_doe",   32'(bus.sram_data_oe), 32'd0);
        chk("rw_state", 32'(dbg_state), 32'(ST_IDLE));
        clear_reqs();
        step();
        rst = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk($sformatf("rw_mem_rdy%0d", k), 32'(bus.mem_ready), 32'd0);
        end
        chk("rw_word", sram_mem[20'h20], 32'h12345678);

        // ---- randomized traffic against the transaction model ----
        for (int i = 0; i < 64; i++) begin
            logic [31:0] w;
            w = $urandom();
            sram_mem[20'(i)] <= w;
            model_mem[20'(i)] = w;
        end
        idle(4);
        exp_if_data = 32'h0;     // reset cleared both data outputs
        exp_mem_rdata = 32'h0;
        mem_got = 1'b0; if_got = 1'b0;
        sv = 1'b0; s_is_if = 1'b0; s_we = 1'b0; s_disc = 1'b0;
        s_start = 0; s_done = 0; free_at = 0; s_data = '0;

        for (int n = 0; n < N_RND; n++) begin
            logic exp_ifr, exp_memr;
            if (n > 0) step();
            if (!bus.mem_ce || mem_got) begin
                if ($urandom_range(0, 2) == 0) begin
                    bus.mem_ce = 1'b1; bus.mem_we = 1'($urandom_range(0, 1));
                    bus.mem_sel = 4'($urandom_range(1, 15)); bus.mem_addr = rand_addr();
                    bus.mem_wdata = $urandom();
                end else begin
                    bus.mem_ce = 1'b0;
                end
            end
            if (!bus.if_ce || if_got) begin
                if ($urandom_range(0, 1) == 0) begin
                    bus.if_ce = 1'b1; bus.if_addr = rand_addr();
                end else begin
                    bus.if_ce = 1'b0;
                end
            end
            bus.flush = ($urandom_range(0, 11) == 0);

            // Completion of the access in flight.
            exp_ifr = 1'b0; exp_memr = 1'b0;
            if (sv && s_done == n) begin
                if (s_is_if) begin
                    if (!s_disc) begin exp_ifr = 1'b1; exp_if_data = s_data; end
                end else begin
                    exp_memr = 1'b1;
                    if (!s_we) exp_mem_rdata = s_data;
                end
                sv = 1'b0;
            end
            // Flush anywhere inside a fetch's SRAM window discards it.
            if (sv && s_is_if && bus.flush && n >= s_start && n <= s_start + W) s_disc = 1'b1;
            // New grant: data port first; busy for W+3 cycles from here.
            if (!sv && n >= free_at && (bus.mem_ce || bus.if_ce)) begin
                logic [19:0] key;
                sv = 1'b1; s_disc = 1'b0;
                s_start = n + 1; s_done = n + 2 + W; free_at = n + 3 + W;
                s_is_if = !bus.mem_ce;
                s_we = bus.mem_ce && bus.mem_we;
                key = s_is_if ? bus.if_addr[21:2] : bus.mem_addr[21:2];
                if (s_we) begin
                    logic [31:0] mask;
                    mask = {{8{bus.mem_sel[3]}}, {8{bus.mem_sel[2]}},
                            {8{bus.mem_sel[1]}}, {8{bus.mem_sel[0]}}};
                    model_mem[key] = (model_rd(key) & ~mask) | (bus.mem_wdata & mask);
                end
                s_data = model_rd(key);
            end

            @(negedge clk);
            chk($sformatf("rnd%0d_if_ready", n),  32'(bus.if_ready),  32'(exp_ifr));
            chk($sformatf("rnd%0d_mem_ready", n), 32'(bus.mem_ready), 32'(exp_memr));
            chk($sformatf("rnd%0d_if_data", n),   bus.if_data,   exp_if_data);
            chk($sformatf("rnd%0d_mem_rdata", n), bus.mem_rdata, exp_mem_rdata);
            chk($sformatf("rnd%0d_stall_if", n),  32'(bus.stallreq_if),  32'(bus.if_ce & ~exp_ifr));
            chk($sformatf("rnd%0d_stall_mem", n), 32'(bus.stallreq_mem), 32'(bus.mem_ce & ~exp_memr));
            mem_got = bus.mem_ready;
            if_got  = bus.if_ready;
        end

        // ---- final report ----
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
